hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 123 ++++++++++++
 tb/tb_hazard_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// multi-cycle mul/div sequencing with timeout and stall statistics.
module hazard_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_if_id,
    input  logic [4:0]       rs2_if_id,
    input  logic             uses_rs2_if_id,
    input  logic [4:0]       rd_id_ex,
    input  logic             mem_read_id_ex,
    input  logic             md_op_id_ex,
    input  logic             branch_taken_ex,
    input  logic             md_done,
    input  logic             stats_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    md_cnt_q, md_cnt_d;
    logic             md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    assign load_use = mem_read_id_ex && (rd_id_ex != 5'd0) &&
                      ((rd_id_ex == rs1_if_id) ||
                       (uses_rs2_if_id && (rd_id_ex == rs2_if_id)));

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        md_timeout_d  = md_timeout_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_go         = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (md_op_id_ex) begin
                    md_go         = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    md_cnt_d      = '0;
                    state_d       = MD_BUSY;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    state_d = RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    md_cnt_d      = md_cnt_q + 1'b1;
                    // Unit never answered: give the pipeline back.
                    if (md_cnt_q == LAST) begin
                        md_timeout_d = 1'b1;
                        state_d      = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stats_clr) begin
            stall_d = '0;
        end else if (!pc_write && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
            stall_q      <= stall_d;
        end
    end

    assign md_timeout   = md_timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller.
module tb_hazard_controller;

    localparam logic [6:0] DEF  = 7'b1110000;
    localparam logic [6:0] LU   = 7'b0010100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] GO   = 7'b0000011;
    localparam logic [6:0] BUSY = 7'b0000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u2, mr, md, br, done, clr;
    logic       pc_write, if_id_write, id_ex_write;
    logic       if_id_flush, id_ex_flush, ex_mem_bubble, md_go;
    logic       md_timeout;
    logic [3:0] stall_cycles;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] sbq[$];
    logic [3:0] exp_stall;
    logic       exp_to;

    hazard_controller #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_if_id(rs1), .rs2_if_id(rs2), .uses_rs2_if_id(u2),
        .rd_id_ex(rd), .mem_read_id_ex(mr), .md_op_id_ex(md),
        .branch_taken_ex(br), .md_done(done), .stats_clr(clr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .md_go(md_go), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_write, if_id_write, id_ex_write, if_id_flush,
                id_ex_flush, ex_mem_bubble, md_go};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic au2, input logic [4:0] ard,
                        input logic amr, input logic amd, input logic abr,
                        input logic adone, input logic aclr,
                        input logic [6:0] exp);
        logic [6:0] e;
        @(negedge clk);
        rs1 = a1; rs2 = a2; u2 = au2; rd = ard; mr = amr;
        md = amd; br = abr; done = adone; clr = aclr;
        sbq.push_back(exp);
        #1;
        e = sbq.pop_front();
        chk(tag, outs(), e);
        chk({tag, "_stall"}, {3'b0, stall_cycles}, {3'b0, exp_stall});
        chk({tag, "_to"}, {6'b0, md_timeout}, {6'b0, exp_to});
        if (aclr) exp_stall = 4'd0;
        else if (!e[6] && exp_stall != 4'hf) exp_stall = exp_stall + 4'd1;
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        step(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic busy(input string tag, input logic abr,
                        input logic adone, input logic [6:0] exp);
        step(tag, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, abr, adone,
             1'b0, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        {u2, mr, md, br, done, clr} = '0;
        exp_stall = 4'd0;
        exp_to = 1'b0;
        #3;
        chk("reset_outs", outs(), DEF);
        chk("reset_stall", {3'b0, stall_cycles}, 7'd0);
        chk("reset_to", {6'b0, md_timeout}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle("idle0", DEF);
        step("lu_rs1", 5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, LU);
        idle("after_lu", DEF);
        step("rd_zero", 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, DEF);
        step("rs2_unused", 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, DEF);
        step("rs2_used", 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, LU);
        step("no_load", 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, DEF);
        step("br_lu", 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, BR);
        step("br_md", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
             1'b0, BR);
        step("done_run", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, DEF);

        // mul/div with done four cycles after the start pulse
        busy("md_go", 1'b0, 1'b0, GO);
        busy("md_b1", 1'b1, 1'b0, BUSY);
        busy("md_b2", 1'b0, 1'b0, BUSY);
        busy("md_b3", 1'b0, 1'b0, BUSY);
        busy("md_done", 1'b0, 1'b1, DEF);
        idle("md_after", DEF);
        step("clr", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, DEF);
        idle("clr_chk", DEF);

        // timeout: eight busy cycles without done
        busy("to_go", 1'b0, 1'b0, GO);
        for (int i = 0; i < 8; i++) busy("to_busy", 1'b0, 1'b0, BUSY);
        exp_to = 1'b1;
        idle("to_run", DEF);

        for (int i = 0; i < 8; i++)
            step("sat_lu", 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, LU);
        idle("sat_chk", DEF);

        busy("sticky_go", 1'b0, 1'b0, GO);
        busy("sticky_done", 1'b0, 1'b1, DEF);
        idle("sticky_chk", DEF);

        // asynchronous reset between edges while busy
        step("rst_go", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, GO);
        step("rst_busy", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, BUSY);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", outs(), DEF);
        chk("arst_stall", {3'b0, stall_cycles}, 7'd0);
        chk("arst_to", {6'b0, md_timeout}, 7'd0);
        exp_stall = 4'd0;
        exp_to = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst0", DEF);
        idle("post_rst1", DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
